// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of a 1-cycle-latency instruction BRAM.
// Owns the PC, pairs each returned word with the PC that fetched it, holds
// that word while decode stalls, and squashes wrong-path words on redirect.
// Optional program loader (writes the BRAM before execution) is enabled by
// defining the macro IF_LOADER_EN; without it reset goes straight to S_START.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  input  logic [31:0] imem_dout,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  output logic        ld_ready,
  output logic        ld_err,
  output logic        running
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

`ifdef IF_LOADER_EN
  localparam state_t RESET_STATE = S_LOAD;
`else
  localparam state_t RESET_STATE = S_START;
`endif

  state_t      state;
  state_t      state_next;

  // Fetch datapath state.
  logic [31:0] fetch_pc;      // next sequential address to issue
  logic        inflight_v;    // a read was issued last cycle; imem_dout carries it now
  logic [31:0] inflight_pc;   // PC of that in-flight read
  logic        hold_v;        // hold register owns the word presented to decode
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  // Redirect targets are word addresses; the low two bits are discarded.
  logic [31:0] redirect_al;
  assign redirect_al = {redirect_pc[31:2], 2'b00};

  assign running = (state == S_RUN);

`ifdef IF_LOADER_EN
  localparam int                LD_W     = $clog2(IMEM_WORDS + 1);
  localparam logic [LD_W-1:0]   LD_LIMIT = LD_W'(IMEM_WORDS);

  logic [LD_W-1:0] ld_cnt;    // number of words written so far
  logic            ld_wr;     // accepted loader word is written this cycle
  logic            ld_drop;   // loader word offered past the end of the BRAM
`else
  // Loader inputs and the redirect low bits have no function in this build.
  logic unused_ld;
  assign unused_ld = ^{ld_valid, ld_data, ld_done, redirect_pc[1:0]};
  assign ld_err    = 1'b0;
`endif

  // Next-state decode and BRAM/loader port drive.
  always_comb begin
    state_next = state;
    imem_en    = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = 32'h0000_0000;
    imem_din   = 32'h0000_0000;
    ld_ready   = 1'b0;
`ifdef IF_LOADER_EN
    ld_wr      = 1'b0;
    ld_drop    = 1'b0;
`endif
    case (state)
      S_LOAD: begin
`ifdef IF_LOADER_EN
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (ld_cnt < LD_LIMIT) begin
            ld_wr     = 1'b1;
            imem_en   = 1'b1;
            imem_we   = 1'b1;
            imem_addr = 32'({ld_cnt, 2'b00});
            imem_din  = ld_data;
          end else begin
            ld_drop = 1'b1;
          end
        end else begin
          ld_wr = 1'b0;
        end
        // A word offered alongside ld_done is still written above.
        if (ld_done) begin
          state_next = S_START;
        end else begin
          state_next = S_LOAD;
        end
`else
        state_next = S_START;
`endif
      end
      S_START: begin
        // BRAM idle for one cycle so the final loader write settles.
        state_next = S_RUN;
      end
      S_RUN: begin
        state_next = S_RUN;
        if (redirect) begin
          imem_en   = 1'b1;
          imem_addr = redirect_al;
        end else if (stall) begin
          imem_en = 1'b0;
        end else begin
          imem_en   = 1'b1;
          imem_addr = fetch_pc;
        end
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // Decode-side outputs: held word wins over the in-flight BRAM word.
  always_comb begin
    if_valid = 1'b0;
    if_instr = 32'h0000_0000;
    if_pc    = 32'h0000_0000;
    if (hold_v) begin
      if_valid = ~redirect;
      if_instr = hold_instr;
      if_pc    = hold_pc;
    end else if (inflight_v) begin
      if_valid = ~redirect;
      if_instr = imem_dout;
      if_pc    = inflight_pc;
    end else begin
      if_valid = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch PC, in-flight tracking and single-entry hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= 32'h0000_0000;
      hold_v      <= 1'b0;
      hold_instr  <= 32'h0000_0000;
      hold_pc     <= 32'h0000_0000;
    end else begin
      case (state)
        S_START: begin
          fetch_pc   <= RESET_PC;
          inflight_v <= 1'b0;
          hold_v     <= 1'b0;
        end
        S_RUN: begin
          if (redirect) begin
            // Any held or in-flight word is wrong-path; drop it.
            fetch_pc    <= redirect_al + 32'd4;
            inflight_pc <= redirect_al;
            inflight_v  <= 1'b1;
            hold_v      <= 1'b0;
          end else if (stall) begin
            // Park the BRAM word before dout is no longer guaranteed.
            if (inflight_v && !hold_v) begin
              hold_instr <= imem_dout;
              hold_pc    <= inflight_pc;
              hold_v     <= 1'b1;
            end else begin
              hold_v <= hold_v;
            end
            inflight_v <= 1'b0;
          end else begin
            // Presented word is consumed this cycle; issue the next one.
            fetch_pc    <= fetch_pc + 32'd4;
            inflight_pc <= fetch_pc;
            inflight_v  <= 1'b1;
            hold_v      <= 1'b0;
          end
        end
        default: begin
          fetch_pc <= fetch_pc;
        end
      endcase
    end
  end

`ifdef IF_LOADER_EN
  // Loader word counter and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt <= '0;
      ld_err <= 1'b0;
    end else begin
      if (ld_wr) begin
        ld_cnt <= ld_cnt + LD_W'(1);
      end else begin
        ld_cnt <= ld_cnt;
      end
      if (ld_drop) begin
        ld_err <= 1'b1;
      end else begin
        ld_err <= ld_err;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed, table-driven bench for instr_fetch with a
// behavioural 32-word, 1-cycle-latency BRAM model. Loader sequences are
// exercised only when IF_LOADER_EN is defined.
module tb_instr_fetch;

`ifdef IF_LOADER_EN
  localparam logic LOADER = 1'b1;
`else
  localparam logic LOADER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;
  logic [31:0] imem_dout = 32'h0000_0000;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        ld_ready;
  logic        ld_err;
  logic        running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
    .imem_dout(imem_dout), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_done(ld_done), .ld_ready(ld_ready),
    .ld_err(ld_err), .running(running)
  );

  // Initial BRAM image: words 0..3 = 0x11,0x22,0x33,0x44, others 0xC0DE_00ii.
  function automatic logic [31:0] init_word(input int i);
    if (i < 4) return 32'(32'h11 * (i + 1));
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  logic [31:0] mem [32];
  bit   [31:0] wr_v;

  // BRAM model: write-enable writes, reads return data one cycle later.
  always @(posedge clk) begin
    if (imem_en) begin
      if (imem_we) begin
        mem[imem_addr[6:2]]  <= imem_din;
        wr_v[imem_addr[6:2]] <= 1'b1;
      end else begin
        imem_dout <= wr_v[imem_addr[6:2]] ? mem[imem_addr[6:2]] : init_word(int'(imem_addr[6:2]));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        run;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic e, input logic [31:0] a, input logic v,
                              input logic [31:0] p, input logic [31:0] ins, input logic rn);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rp; t.en = e; t.addr = a;
    t.valid = v; t.pc = p; t.instr = ins; t.run = rn;
    return t;
  endfunction

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL timeout act=%0t exp=finish", $time);
    $fatal(1);
  end

  initial begin
    //            stall redir rpc            en    addr           valid pc            instr          run
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0); // S_START
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'h11,        1'b1);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         32'h22,        1'b1); // stall x3
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         32'h22,        1'b1);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         32'h22,        1'b1);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h4,         32'h22,        1'b1); // release
    vecs[7]  = mk(1'b0, 1'b1, 32'h40,        1'b1, 32'h40,        1'b0, 32'h0,         32'h0,         1'b1); // redirect at pc 8
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h44,        1'b1, 32'h40,        32'hC0DE_0010, 1'b1);
    vecs[9]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h44,        32'hC0DE_0011, 1'b1);
    vecs[10] = mk(1'b1, 1'b1, 32'h43,        1'b1, 32'h40,        1'b0, 32'h0,         32'h0,         1'b1); // redirect+stall
    vecs[11] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40,        32'hC0DE_0010, 1'b1);
    vecs[12] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40,        32'hC0DE_0010, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h44,        1'b1, 32'h40,        32'hC0DE_0010, 1'b1);
    vecs[14] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0,         1'b1);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'hC0DE_001F, 1'b1); // wrap

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ld_valid = 1'b0; ld_data = 32'h0; ld_done = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_imem_en",  {31'b0, imem_en},  32'h0);
    chk("rst_imem_we",  {31'b0, imem_we},  32'h0);
    chk("rst_imem_addr", imem_addr,        32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_pc",    if_pc,             32'h0);
    chk("rst_running",  {31'b0, running},  32'h0);
    chk("rst_ld_err",   {31'b0, ld_err},   32'h0);
    chk("rst_ld_ready", {31'b0, ld_ready}, {31'b0, LOADER});
    rst = 1'b0;

`ifdef IF_LOADER_EN
    // Load 4 words, last one together with ld_done.
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'(32'h11 * (i + 1));
      ld_done  = (i == 3);
      #1;
      chk("ld_en",    {31'b0, imem_en},  32'h1);
      chk("ld_we",    {31'b0, imem_we},  32'h1);
      chk("ld_addr",  imem_addr,         32'(i * 4));
      chk("ld_din",   imem_din,          32'(32'h11 * (i + 1)));
      chk("ld_ready", {31'b0, ld_ready}, 32'h1);
      chk("ld_run",   {31'b0, running},  32'h0);
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_done = 1'b0;
`endif

    // Main fetch sequence.
    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].stall; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_en", i),    {31'b0, imem_en},  {31'b0, vecs[i].en});
      chk($sformatf("v%0d_we", i),    {31'b0, imem_we},  32'h0);
      if (vecs[i].en) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].valid});
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_pc", i),    if_pc,    vecs[i].pc);
        chk($sformatf("v%0d_instr", i), if_instr, vecs[i].instr);
      end
      chk($sformatf("v%0d_run", i),   {31'b0, running},  {31'b0, vecs[i].run});
      chk($sformatf("v%0d_ldrdy", i), {31'b0, ld_ready}, 32'h0);
      @(negedge clk);
    end
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Async reset mid-run.
    rst = 1'b1;
    #1;
    chk("mid_rst_en",    {31'b0, imem_en},  32'h0);
    chk("mid_rst_valid", {31'b0, if_valid}, 32'h0);
    chk("mid_rst_pc",    if_pc,             32'h0);
    chk("mid_rst_run",   {31'b0, running},  32'h0);
    chk("mid_rst_lderr", {31'b0, ld_err},   32'h0);
    @(negedge clk);
    rst = 1'b0;

`ifdef IF_LOADER_EN
    // 33 words into a 32-word BRAM: last one dropped, ld_err sticks.
    for (int i = 0; i < 33; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h5000_0000 + 32'(i);
      #1;
      chk("ov_en",    {31'b0, imem_en}, (i < 32) ? 32'h1 : 32'h0);
      if (i < 32) chk("ov_addr", imem_addr, 32'(i * 4));
      chk("ov_lderr", {31'b0, ld_err},  32'h0);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #1;
    chk("ov_lderr_set", {31'b0, ld_err}, 32'h1);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    #1;
    chk("ov_lderr_sticky", {31'b0, ld_err}, 32'h1);
    chk("ov_ldready_off",  {31'b0, ld_ready}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ov_running", {31'b0, running}, 32'h1);
    rst = 1'b1;
    #1;
    chk("ov_rst_lderr", {31'b0, ld_err},  32'h0);
    chk("ov_rst_run",   {31'b0, running}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
`else
    // Restart after reset: S_START, then fetch from address 0 again.
    #1;
    chk("re_start_run", {31'b0, running}, 32'h0);
    @(negedge clk);
    #1;
    chk("re_en",   {31'b0, imem_en}, 32'h1);
    chk("re_addr", imem_addr,        32'h0);
    @(negedge clk);
    #1;
    chk("re_valid", {31'b0, if_valid}, 32'h1);
    chk("re_pc",    if_pc,             32'h0);
    chk("re_instr", if_instr,          32'h11);
    chk("re_addr2", imem_addr,         32'h4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
